delta_fifo_ctrl: RTL and testbench

Stream-to-SRAM FIFO controller that sits directly upstream of the delta SRAM wrapper (64x28, one write port and one read port, but a single-port macro underneath, with 1-cycle read latency).
- Accepts delta words on a valid/ready input stream and writes them into the RAM as a circular buffer.
- Issues reads, captures the returning data into a 2-entry output buffer, and presents it on a valid/ready output stream.
- Arbitrates the single physical port: write wins by default; read wins only to avoid starving the output.

---
 rtl/delta_fifo_ctrl_pkg.sv | 7 +
 rtl/delta_fifo_ctrl_if.sv | 23 ++
 rtl/delta_out_skid.sv | 54 +++++
 rtl/delta_fifo_ctrl.sv | 90 +++++++++
 tb/tb_delta_fifo_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/delta_fifo_ctrl_pkg.sv
// Shared widths and word type for the delta FIFO controller.
package delta_fifo_ctrl_pkg;
  localparam int unsigned DELTA_WIDTH      = 28;
  localparam int unsigned DELTA_ADDR_WIDTH = 6;

  typedef logic [DELTA_WIDTH-1:0] delta_t;
endpackage

// File: rtl/delta_fifo_ctrl_if.sv
// Input and output valid/ready streams of the delta FIFO controller.
interface delta_fifo_ctrl_if;
  import delta_fifo_ctrl_pkg::*;

  logic   in_valid;
  logic   in_ready;
  delta_t in_data;
  logic   out_valid;
  logic   out_ready;
  delta_t out_data;

  // Producer/consumer side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Controller side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/delta_out_skid.sv
// Two-entry output buffer: captures RAM read returns, presents head on the output stream.
module delta_out_skid
  import delta_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DELTA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  cap,
  input  logic [DATA_WIDTH-1:0] cap_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            ob_cnt
);

  logic [DATA_WIDTH-1:0] ob0;
  logic [DATA_WIDTH-1:0] ob1;
  logic                  pop;
  logic [1:0]            base;

  // Pop decode and capture slot (occupancy after this cycle's pop)
  always_comb begin
    out_valid = (ob_cnt != 2'd0);
    out_data  = ob0;
    pop       = out_valid && out_ready;
    base      = ob_cnt - {1'b0, pop};
  end

  // Shift on pop, then place returning data behind the surviving entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob0    <= '0;
      ob1    <= '0;
      ob_cnt <= 2'd0;
    end else if (flush) begin
      ob_cnt <= 2'd0;
    end else begin
      if (pop) begin
        ob0 <= ob1;
      end
      if (cap) begin
        if (base == 2'd0) begin
          ob0 <= cap_data;
        end else begin
          ob1 <= cap_data;
        end
      end
      ob_cnt <= base + {1'b0, cap};
    end
  end

endmodule

// File: rtl/delta_fifo_ctrl.sv
// Stream-to-SRAM circular FIFO controller with single-port read/write arbitration.
module delta_fifo_ctrl
  import delta_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DELTA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DELTA_ADDR_WIDTH,
  parameter int unsigned DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  delta_fifo_ctrl_if.slave      bus,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_addr_w,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_read_en,
  output logic [ADDR_WIDTH-1:0] ram_addr_r,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam int unsigned CW = ADDR_WIDTH + 2;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] ram_cnt;
  logic          inflight;
  logic          run;
  logic          read_pri;
  logic          wr_fire;
  logic          rd_fire;
  logic [1:0]    ob_cnt;

  // Port arbitration: write wins unless the output side would starve
  always_comb begin
    ram_cnt      = wr_ptr - rd_ptr;
    read_pri     = (ram_cnt != '0) && (ob_cnt == 2'd0) && !inflight;
    bus.in_ready = run && !flush && (ram_cnt < PW'(DEPTH)) && !read_pri;
    wr_fire      = bus.in_valid && bus.in_ready;
    rd_fire      = !flush && !wr_fire && (ram_cnt != '0)
                   && (({1'b0, ob_cnt} + {2'b00, inflight}) < 3'd2);
    ram_write_en = wr_fire;
    ram_addr_w   = wr_ptr[ADDR_WIDTH-1:0];
    ram_data_in  = wr_fire ? bus.in_data : '0;
    ram_read_en  = rd_fire;
    ram_addr_r   = rd_ptr[ADDR_WIDTH-1:0];
    count        = CW'(ram_cnt) + CW'(inflight) + CW'(ob_cnt);
  end

  // Pointers, read-in-flight flag and post-reset run enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      run      <= 1'b0;
    end else begin
      run <= 1'b1;
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        inflight <= 1'b0;
      end else begin
        if (wr_fire) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (rd_fire) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        inflight <= rd_fire;
      end
    end
  end

  delta_out_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .cap       (inflight),
    .cap_data  (ram_data_out),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_data  (bus.out_data),
    .ob_cnt    (ob_cnt)
  );

endmodule

// File: tb/tb_delta_fifo_ctrl.sv
// Scoreboard bench for delta_fifo_ctrl with a behavioural RAM and a queue reference model.
module tb_delta_fifo_ctrl;
  import delta_fifo_ctrl_pkg::*;

  localparam int unsigned DW    = DELTA_WIDTH;
  localparam int unsigned AW    = DELTA_ADDR_WIDTH;
  localparam int unsigned DEPTH = 2**AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [AW+1:0] count;
  logic          ram_write_en;
  logic [AW-1:0] ram_addr_w;
  logic [DW-1:0] ram_data_in;
  logic          ram_read_en;
  logic [AW-1:0] ram_addr_r;
  logic [DW-1:0] ram_data_out = '0;

  always #5 clk = ~clk;

  delta_fifo_ctrl_if bus ();

  delta_fifo_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus.slave),
    .count        (count),
    .ram_write_en (ram_write_en),
    .ram_addr_w   (ram_addr_w),
    .ram_data_in  (ram_data_in),
    .ram_read_en  (ram_read_en),
    .ram_addr_r   (ram_addr_r),
    .ram_data_out (ram_data_out)
  );

  // Behavioural SRAM, 1-cycle read latency
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_addr_w] <= ram_data_in;
    if (ram_read_en)  ram_data_out   <= mem[ram_addr_r];
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int wraps  = 0;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: FIFO occupancy model, ordering scoreboard, port exclusivity
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      exp_q.delete();
    end else begin
      check("count", 64'(count), 64'(exp_q.size()));
      check("rw_exclusive", 64'(ram_write_en && ram_read_en), 64'd0);
      if (exp_q.size() == DEPTH + 2) check("full_in_ready", 64'(bus.in_ready), 64'd0);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) check("pop_when_empty", 64'(bus.out_valid), 64'd0);
          else check("out_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
        end
        if (bus.in_valid && bus.in_ready) exp_q.push_back(bus.in_data);
        if (ram_write_en && ram_addr_w == AW'(DEPTH - 1)) wraps++;
      end
    end
  end

  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (count == '0 && !bus.out_valid) done = 1'b1;
      else drive_point();
    end
    if (!done) check("drain_timeout", 64'(count), 64'd0);
    drive_point();
  endtask

  task automatic push_n(input int n, input bit ready);
    int acc;
    acc = 0;
    bus.out_ready = ready;
    for (int c = 0; c < 1000 && acc < n; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'($urandom);
      @(negedge clk);
      if (bus.in_ready) acc++;
      drive_point();
    end
    bus.in_valid = 1'b0;
    check("push_n_accepted", 64'(acc), 64'(n));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int w0;
    bus.in_valid  = 1'b1;
    bus.in_data   = DW'(28'h0ABCDEF);
    bus.out_ready = 1'b0;

    // Reset held with in_valid=1, release mid-cycle
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    drive_point();
    @(negedge clk);
    check("ready_after_rst", 64'(bus.in_ready), 64'd1);
    drive_point();
    drain();

    // Return pointers to zero, then single-word latency
    flush = 1'b1;
    drive_point();
    flush = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = DW'(1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("lat_t_we", 64'(ram_write_en), 64'd1);
    check("lat_t_addr_w", 64'(ram_addr_w), 64'd0);
    check("lat_t_data_in", 64'(ram_data_in), 64'd1);
    drive_point();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat_t1_re", 64'(ram_read_en), 64'd1);
    check("lat_t1_addr_r", 64'(ram_addr_r), 64'd0);
    check("lat_t1_in_ready", 64'(bus.in_ready), 64'd0);
    drive_point();
    @(negedge clk);
    check("lat_t2_out_valid", 64'(bus.out_valid), 64'd0);
    drive_point();
    @(negedge clk);
    check("lat_t3_out_valid", 64'(bus.out_valid), 64'd1);
    check("lat_t3_out_data", 64'(bus.out_data), 64'd1);
    drive_point();
    @(negedge clk);
    check("lat_count_after_pop", 64'(count), 64'd0);
    drive_point();

    // Fill with consumer stalled: 64 in RAM + 2 in output buffer
    acc = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 300 && acc < 70; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(acc);
      @(negedge clk);
      if (bus.in_ready) acc++;
      drive_point();
    end
    check("full_accepted", 64'(acc), 64'd66);
    @(negedge clk);
    check("full_count", 64'(count), 64'd66);
    check("full_ready_low", 64'(bus.in_ready), 64'd0);
    drive_point();
    drain();

    // Continuous push/pop of 200 words across pointer wraps
    w0 = wraps;
    push_n(200, 1'b1);
    drain();
    check("wraps_ge_3", 64'((wraps - w0) >= 3), 64'd1);

    // Flush with count=10 and a read in flight
    push_n(11, 1'b0);
    repeat (4) drive_point();
    bus.out_ready = 1'b1;
    drive_point();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("flush_setup_read", 64'(ram_read_en), 64'd1);
    drive_point();
    flush = 1'b1;
    @(negedge clk);
    check("flush_count_before", 64'(count), 64'd10);
    drive_point();
    flush = 1'b0;
    @(negedge clk);
    check("flush_count_after", 64'(count), 64'd0);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    drive_point();
    @(negedge clk);
    check("flush_no_late_capture", 64'(bus.out_valid), 64'd0);
    drive_point();

    // Randomised traffic with occasional flush
    for (int c = 0; c < 600; c++) begin
      flush         = (($urandom % 97) == 0);
      bus.in_valid  = (($urandom % 4) != 0);
      bus.in_data   = DW'($urandom);
      bus.out_ready = flush ? 1'b0 : 1'(($urandom % 3) != 0);
      drive_point();
    end
    flush = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
